// File: rtl/uart_pkg.sv
// Shared types and sizes for the UART receive path.
package uart_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CPB_W       = 10;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BIT_IDX_W   = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Parity bit value that makes the total count of ones even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver byte stream: valid/ready payload plus error flags.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
`ifdef UART_RX_PARITY_EN
    logic              parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    import uart_pkg::*;

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= {SYNC_STAGES{RST_VAL}};
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver with runtime bit period and valid/ready output.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_pin,
    input  logic [CPB_W-1:0] clk_per_bit,
    uart_rx_if.master        rx
);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CPB_W-1:0]     cpb_q, cpb_d;
    logic [CPB_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic                 bit_end_c;
    logic                 half_end_c;
    logic                 load_c;
    logic                 frame_err_c;
    logic                 hs_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_c;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx_pin),
        .q   (rx_s)
    );

    assign bit_end_c  = (cnt_q == cpb_q - CPB_W'(1));
    assign half_end_c = (cnt_q == (cpb_q >> 1) - CPB_W'(1));
    assign hs_c       = rx.rx_valid && rx.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cpb_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cpb_q   <= cpb_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_bad_q <= 1'b0;
        else     par_bad_q <= par_bad_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cpb_d       = cpb_q;
        cnt_d       = cnt_q + CPB_W'(1);
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        load_c      = 1'b0;
        frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s && clk_per_bit != '0) begin
                    cpb_d   = clk_per_bit;
                    state_d = START;
                end
            end
            // Mid-start-bit recheck rejects short low glitches.
            START: begin
                if (half_end_c) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                    bit_d   = bit_q + BIT_IDX_W'(1);
                    if (bit_q == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (rx_s != even_par(shreg_q)) begin
                        parity_err_c = 1'b1;
                        par_bad_d    = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        load_c  = !par_bad_q;
`else
                        load_c  = 1'b1;
`endif
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            // Hold off start detection until the line break ends.
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            rx.frame_err <= frame_err_c;
            if (load_c) begin
                rx.rx_data  <= shreg_q;
                rx.rx_valid <= 1'b1;
            end else if (hs_c) begin
                rx.rx_valid <= 1'b0;
            end
            // Overwriting an unconsumed byte is an overrun; a handshake clears it.
            if (load_c && rx.rx_valid && !rx.rx_ready) rx.overrun <= 1'b1;
            else if (hs_c)                             rx.overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) rx.parity_err <= 1'b0;
        else     rx.parity_err <= parity_err_c;
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core (8N1, or 8E1 with UART_RX_PARITY_EN).
module tb_uart_rx_core;
    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
    logic par_flip = 1'b0;
    int   n_pe = 0;
`else
    localparam int NBITS = 9;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_pin = 1'b1;
    logic [CPB_W-1:0] clk_per_bit = CPB_W'(16);

    uart_rx_if rx_if ();

    uart_rx_core dut (
        .clk         (clk),
        .rst         (rst),
        .rx_pin      (rx_pin),
        .clk_per_bit (clk_per_bit),
        .rx          (rx_if)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   n_rise = 0;
    int   n_fe = 0;
    logic prev_v = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_if.rx_valid && !prev_v) begin
            n_rise   = n_rise + 1;
            rise_cyc = cyc;
        end
        prev_v = rx_if.rx_valid;
        if (rx_if.frame_err) n_fe = n_fe + 1;
`ifdef UART_RX_PARITY_EN
        if (rx_if.parity_err) n_pe = n_pe + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_pin = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int n;
        n = int'(clk_per_bit);
        start_cyc = cyc;
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, n);
`endif
        send_bit(stop, n);
    endtask

    int r0, f0;

    initial begin
        rx_if.rx_ready = 1'b0;
        tick(3);
        check("rst_data",    32'(rx_if.rx_data),   32'h0);
        check("rst_valid",   32'(rx_if.rx_valid),  32'h0);
        check("rst_ferr",    32'(rx_if.frame_err), 32'h0);
        check("rst_overrun", 32'(rx_if.overrun),   32'h0);
        rst = 1'b0;
        tick(2);

        // Single byte, consumer always ready; rise = CPB/2 + NBITS*CPB + 3 from pin drive.
        rx_if.rx_ready = 1'b1;
        r0 = n_rise;
        send_frame(8'hA5, 1'b1);
        tick(4);
        check("a5_rises",   32'(n_rise - r0),          32'd1);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(8 + NBITS * 16 + 3));
        check("a5_data",    32'(rx_if.rx_data),        32'hA5);
        check("a5_valid",   32'(rx_if.rx_valid),       32'h0);
        check("a5_ferr",    32'(n_fe),                 32'd0);
        check("a5_overrun", 32'(rx_if.overrun),        32'h0);

        // Two back-to-back bytes without a consumer: overrun.
        rx_if.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(4);
        check("ovr_data",  32'(rx_if.rx_data),  32'hC3);
        check("ovr_valid", 32'(rx_if.rx_valid), 32'h1);
        check("ovr_flag",  32'(rx_if.overrun),  32'h1);
        rx_if.rx_ready = 1'b1;
        tick(1);
        rx_if.rx_ready = 1'b0;
        check("hs_valid",   32'(rx_if.rx_valid), 32'h0);
        check("hs_overrun", 32'(rx_if.overrun),  32'h0);

        // Bad stop bit followed by a held-low line break.
        r0 = n_rise;
        f0 = n_fe;
        send_frame(8'h55, 1'b0);
        send_bit(1'b0, 40);
        send_bit(1'b1, 200);
        check("brk_ferr",  32'(n_fe - f0),      32'd1);
        check("brk_rises", 32'(n_rise - r0),    32'd0);
        check("brk_valid", 32'(rx_if.rx_valid), 32'h0);
        check("brk_data",  32'(rx_if.rx_data),  32'hC3);

        // Short low glitch, then a real frame to show the receiver recovered.
        r0 = n_rise;
        f0 = n_fe;
        send_bit(1'b0, 4);
        send_bit(1'b1, 200);
        check("gl_rises", 32'(n_rise - r0), 32'd0);
        check("gl_ferr",  32'(n_fe - f0),   32'd0);
        rx_if.rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(4);
        check("gl_next_data",  32'(rx_if.rx_data), 32'h5A);
        check("gl_next_rises", 32'(n_rise - r0),   32'd1);

        // Receiver disabled with a toggling line.
        clk_per_bit = '0;
        r0 = n_rise;
        f0 = n_fe;
        for (int i = 0; i < 20; i++) send_bit(i[0], 7);
        send_bit(1'b1, 300);
        check("dis_rises", 32'(n_rise - r0), 32'd0);
        check("dis_ferr",  32'(n_fe - f0),   32'd0);

        // Reset in the middle of a frame at 32 clocks per bit.
        clk_per_bit = CPB_W'(32);
        send_bit(1'b0, 32);
        send_bit(1'b1, 32);
        send_bit(1'b0, 32);
        rst    = 1'b1;
        rx_pin = 1'b1;
        tick(1);
        check("mid_rst_data",    32'(rx_if.rx_data),   32'h0);
        check("mid_rst_valid",   32'(rx_if.rx_valid),  32'h0);
        check("mid_rst_ferr",    32'(rx_if.frame_err), 32'h0);
        check("mid_rst_overrun", 32'(rx_if.overrun),   32'h0);
        rst = 1'b0;
        tick(100);
        r0 = n_rise;
        send_frame(8'h81, 1'b1);
        tick(4);
        check("r81_data",    32'(rx_if.rx_data),        32'h81);
        check("r81_rises",   32'(n_rise - r0),          32'd1);
        check("r81_latency", 32'(rise_cyc - start_cyc), 32'(16 + NBITS * 32 + 3));

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit is 1.
        clk_per_bit = CPB_W'(16);
        r0 = n_rise;
        f0 = n_pe;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        tick(4);
        check("par_ok_data",  32'(rx_if.rx_data), 32'h07);
        check("par_ok_rises", 32'(n_rise - r0),   32'd1);
        check("par_ok_pe",    32'(n_pe - f0),     32'd0);
        r0 = n_rise;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        tick(4);
        check("par_bad_pe",    32'(n_pe - f0),      32'd1);
        check("par_bad_rises", 32'(n_rise - r0),    32'd0);
        check("par_bad_valid", 32'(rx_if.rx_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
